// File: rtl/imem_loader.sv
// imem_loader: assembles an MSB-first byte stream into 32-bit instruction-memory writes while holding the CPU.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  word_count,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        we,
   output logic [31:0] waddr,
   output logic [31:0] wdata,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        err
);
   typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;
   state_t      r_state;
   logic [23:0] r_shift;
   logic [1:0]  r_bytes;
   logic [7:0]  r_words;
   logic [7:0]  r_count;
   logic [31:0] r_addr;
   logic        w_take;
   assign w_take = rx_valid && rx_ready;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] r_csum;
   logic       r_err;
   assign err = r_err;
`else
   assign err = 1'b0;
`endif
   // waddr/wdata are output copies loaded only on entry to WRITE; r_addr is the running pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         rx_ready <= 1'b0;
         we       <= 1'b0;
         waddr    <= BASE_ADDR;
         wdata    <= 32'd0;
         cpu_hold <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         r_shift  <= 24'd0;
         r_bytes  <= 2'd0;
         r_words  <= 8'd0;
         r_count  <= 8'd0;
         r_addr   <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
         r_csum   <= 8'd0;
         r_err    <= 1'b0;
`endif
      end else begin
         we   <= 1'b0;
         done <= 1'b0;
         case (r_state)
            IDLE: if (start) begin
               cpu_hold <= 1'b1;
               busy     <= 1'b1;
               r_addr   <= BASE_ADDR;
               r_bytes  <= 2'd0;
               r_words  <= 8'd0;
               r_count  <= word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
               r_csum   <= 8'd0;
               r_err    <= 1'b0;
`endif
               if (word_count != 8'd0) begin
                  r_state  <= RECV;
                  rx_ready <= 1'b1;
               end else begin
                  r_state <= DONE;
                  done    <= 1'b1;
               end
            end
            RECV: if (w_take) begin
               r_bytes <= r_bytes + 2'd1;
               r_shift <= {r_shift[15:0], rx_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
               r_csum  <= r_csum ^ rx_data;
`endif
               if (r_bytes == 2'd3) begin
                  wdata    <= {r_shift, rx_data};
                  waddr    <= r_addr;
                  we       <= 1'b1;
                  rx_ready <= 1'b0;
                  r_state  <= WRITE;
               end
            end
            WRITE: begin
               r_addr  <= r_addr + 32'd4;
               r_words <= r_words + 8'd1;
               if (r_words + 8'd1 < r_count) begin
                  r_state  <= RECV;
                  rx_ready <= 1'b1;
               end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_state  <= CHECK;
                  rx_ready <= 1'b1;
`else
                  r_state <= DONE;
                  done    <= 1'b1;
`endif
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: if (w_take) begin
               r_err    <= rx_data != r_csum;
               rx_ready <= 1'b0;
               r_state  <= DONE;
               done     <= 1'b1;
            end
`endif
            DONE: begin
               r_state  <= IDLE;
               cpu_hold <= 1'b0;
               busy     <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench comparing recorded memory writes with a byte-level model.
module tb_imem_loader;
   localparam logic [31:0] BASE = 32'h0000_1000;
   logic        clk = 0, reset = 1, start = 0, rx_valid = 0;
   logic [7:0]  word_count = 0, rx_data = 0;
   logic        rx_ready, we, cpu_hold, busy, done, err;
   logic [31:0] waddr, wdata;
   int          errors = 0, checks = 0, done_cnt = 0;
   logic [31:0] got_a[$], got_d[$];
   bit          got_ok[$];
   logic        prev_we = 0;

   imem_loader #(.BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .start(start), .word_count(word_count),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .we(we),
      .waddr(waddr), .wdata(wdata), .cpu_hold(cpu_hold), .busy(busy),
      .done(done), .err(err));

   always #5 clk = ~clk;

   // record every write with a flag saying it was single-cycle and not overlapping rx_ready
   always @(negedge clk) begin
      if (we) begin
         got_a.push_back(waddr);
         got_d.push_back(wdata);
         got_ok.push_back(!prev_we && !rx_ready);
      end
      if (done) done_cnt <= done_cnt + 1;
      prev_we <= we;
   end

   task automatic clear_log();
      got_a.delete(); got_d.delete(); got_ok.delete(); done_cnt = 0;
   endtask

   task automatic do_start(input logic [7:0] n);
      start = 1; word_count = n;
      @(posedge clk); #1;
      start = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int idle);
      int k = 0;
      repeat (idle) begin rx_valid = 0; @(posedge clk); #1; end
      rx_valid = 1; rx_data = b;
      forever begin
         @(negedge clk);
         if (rx_ready) break;
         k++;
         if (k > 50) begin
            checks++; errors++;
            $display("FAIL rx_ready_timeout: rx_ready=%0b, required 1 within 50 cycles", rx_ready);
            rx_valid = 0;
            return;
         end
      end
      @(posedge clk); #1;
      rx_valid = 0;
   endtask

   task automatic wait_done(input string tag, input logic exp_err);
      int k = 0;
      forever begin
         @(negedge clk);
         if (done) break;
         k++;
         if (k > 200) begin
            checks++; errors++;
            $display("FAIL %s done_timeout: done=%0b, required 1", tag, done);
            return;
         end
      end
      checks++;
      if (cpu_hold !== 1 || busy !== 1 || err !== exp_err) begin errors++;
         $display("FAIL %s at_done: hold=%0b busy=%0b err=%0b, required 1 1 %0b", tag, cpu_hold, busy, err, exp_err); end
      @(negedge clk);
      checks++;
      if (cpu_hold !== 0 || busy !== 0 || done !== 0 || done_cnt !== 1 || err !== exp_err) begin errors++;
         $display("FAIL %s after_done: hold=%0b busy=%0b done=%0b pulses=%0d err=%0b, required 0 0 0 1 %0b",
                  tag, cpu_hold, busy, done, done_cnt, err, exp_err); end
   endtask

   // model: word i is bytes 4i..4i+3 big-endian at BASE + 4i
   task automatic check_writes(input string tag, input logic [7:0] b[$], input int n);
      logic [31:0] ea, ed;
      checks++;
      if (got_a.size() != n) begin errors++;
         $display("FAIL %s write_count: got %0d, required %0d", tag, got_a.size(), n); return; end
      for (int i = 0; i < n; i++) begin
         ea = BASE + 32'(4 * i);
         ed = 32'(b[4*i]) * 32'h0100_0000 + 32'(b[4*i+1]) * 32'h1_0000 + 32'(b[4*i+2]) * 32'h100 + 32'(b[4*i+3]);
         checks++;
         if (got_a[i] !== ea || got_d[i] !== ed || !got_ok[i]) begin errors++;
            $display("FAIL %s write%0d: addr=%h data=%h clean=%0b, required %h %h 1", tag, i, got_a[i], got_d[i], got_ok[i], ea, ed); end
      end
   endtask

   task automatic run_load(input string tag, input logic [7:0] b[$], input int n, input int gap, input logic bad_csum);
      logic [7:0] x = 0;
      clear_log();
      do_start(8'(n));
      foreach (b[i]) begin send_byte(b[i], $urandom_range(0, gap)); x ^= b[i]; end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(bad_csum ? ~x : x, 0);
`endif
      wait_done(tag, bad_csum);
      check_writes(tag, b, n);
   endtask

   task automatic test_reset();
      reset = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (rx_ready !== 0 || we !== 0 || waddr !== BASE || wdata !== 0 || cpu_hold !== 0 || busy !== 0 || done !== 0 || err !== 0) begin
         errors++;
         $display("FAIL reset_state: rdy=%0b we=%0b waddr=%h wdata=%h hold=%0b busy=%0b done=%0b err=%0b, required 0 0 %h 0 0 0 0 0",
                  rx_ready, we, waddr, wdata, cpu_hold, busy, done, err, BASE);
      end
      @(posedge clk); #1;
      reset = 0;
   endtask

   task automatic test_vector();
      logic [7:0] b[$] = '{8'h20, 8'h04, 8'h00, 8'h03, 8'h0C, 8'h00, 8'h00, 8'h03, 8'h10, 8'h00, 8'hFF, 8'hFF};
      run_load("vector", b, 3, 0, 0);
      checks++;
      if (waddr !== BASE + 32'h8 || wdata !== 32'h1000FFFF) begin errors++;
         $display("FAIL vector_hold: waddr=%h wdata=%h, required %h 1000ffff", waddr, wdata, BASE + 32'h8); end
   endtask

   task automatic test_toggle_valid();
      logic [7:0] b[$];
      repeat (4) b.push_back(8'($urandom));
      clear_log();
      do_start(1);
      foreach (b[i]) begin
         rx_valid = 0; rx_data = ~b[i]; @(posedge clk); #1;
         send_byte(b[i], 0);
      end
      wait_done("toggle", 0);
      check_writes("toggle", b, 1);
   endtask

   task automatic test_zero_count();
      clear_log();
      do_start(0);
      @(negedge clk);
      checks++;
      if (done !== 1 || cpu_hold !== 1) begin errors++;
         $display("FAIL zero_done: done=%0b hold=%0b, required 1 1", done, cpu_hold); end
      @(negedge clk);
      checks++;
      if (done !== 0 || cpu_hold !== 0 || got_a.size() != 0 || done_cnt !== 1) begin errors++;
         $display("FAIL zero_after: done=%0b hold=%0b writes=%0d pulses=%0d, required 0 0 0 1", done, cpu_hold, got_a.size(), done_cnt); end
   endtask

   task automatic test_reset_midload();
      logic [7:0] b[$];
      repeat (4) b.push_back(8'($urandom));
      clear_log();
      do_start(2);
      foreach (b[i]) send_byte(b[i], 0);
      send_byte(8'hAA, 0);
      send_byte(8'h55, 0);
      rx_valid = 1; rx_data = 8'h77; start = 1; word_count = 3; reset = 1;
      @(posedge clk); #1;
      reset = 0; rx_valid = 0; start = 0;
      @(negedge clk);
      checks++;
      if (busy !== 0 || cpu_hold !== 0 || rx_ready !== 0 || waddr !== BASE || wdata !== 0) begin errors++;
         $display("FAIL midreset_state: busy=%0b hold=%0b rdy=%0b waddr=%h wdata=%h, required 0 0 0 %h 0", busy, cpu_hold, rx_ready, waddr, wdata, BASE); end
      repeat (3) @(negedge clk);
      check_writes("midreset_partial", b, 1);
      b.delete();
      repeat (4) b.push_back(8'($urandom));
      run_load("after_reset", b, 1, 1, 0);
   endtask

   task automatic test_start_in_recv();
      logic [7:0] b[$];
      repeat (8) b.push_back(8'($urandom));
      clear_log();
      do_start(2);
      for (int i = 0; i < 8; i++) begin
         if (i == 2 || i == 5) begin start = 1; word_count = 8'd9; @(posedge clk); #1; start = 0; end
         send_byte(b[i], 0);
      end
      wait_done("start_in_recv", 0);
      check_writes("start_in_recv", b, 2);
   endtask

   task automatic test_random();
      for (int t = 0; t < 6; t++) begin
         logic [7:0] b[$];
         int n = $urandom_range(1, 4);
         repeat (4 * n) b.push_back(8'($urandom));
         run_load($sformatf("random%0d", t), b, n, 2, 0);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      logic [7:0] b[$] = '{8'h20, 8'h04, 8'h00, 8'h03};
      run_load("csum_bad", b, 1, 0, 1);
      run_load("csum_good", b, 1, 0, 0);
   endtask
`endif

   initial begin
      test_reset();
      test_vector();
      test_toggle_valid();
      test_zero_count();
      test_reset_midload();
      test_start_in_recv();
      test_random();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
